// File: rtl/alu_regfile_pipe.sv
// Register file plus ALU with a two-stage valid/ready pipeline and an NZCV flags register.
// Stage 0 reads operands with bypass from stage 1; stage 1 executes and retires into the output register.
module alu_regfile_pipe #(
    parameter int ADDR_BITS = 3,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic [ADDR_BITS-1:0] addr_a,
    input  logic [ADDR_BITS-1:0] addr_b,
    input  logic [ADDR_BITS-1:0] addr_r,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic [3:0]           out_flags
);
    localparam int NUM_REGS = 2 ** ADDR_BITS;
    localparam int MSB      = DATA_BITS - 1;

    localparam logic [3:0] OP_READ  = 4'd1;
    localparam logic [3:0] OP_WRITE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_ADC   = 4'd5;
    localparam logic [3:0] OP_SBC   = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_XOR   = 4'd9;
    localparam logic [3:0] OP_CMP   = 4'd10;

    logic [DATA_BITS-1:0] rf_q [NUM_REGS];
    logic [3:0]           flags_q, flags_d;

    logic                 s1_valid_q;
    logic [3:0]           s1_op_q;
    logic [DATA_BITS-1:0] s1_a_q, s1_b_q, s1_din_q;
    logic [ADDR_BITS-1:0] s1_dest_q;

    logic                 out_valid_q;
    logic [DATA_BITS-1:0] out_data_q;
    logic [3:0]           out_flags_q;

    logic                 adv, accept;
    logic                 wr_en, flag_upd, arith;
    logic [DATA_BITS-1:0] res_d, opb, opa_byp, opb_byp;
    logic                 cin;
    logic [DATA_BITS:0]   sum;

    assign adv       = !out_valid_q || out_ready;
    assign accept    = adv && in_valid;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

    // Stage-1 execute; ADC/SBC take carry from flags_q, which already reflects every older command.
    always_comb begin
        res_d    = '0;
        opb      = s1_b_q;
        cin      = 1'b0;
        arith    = 1'b0;
        wr_en    = 1'b0;
        flag_upd = 1'b0;
        case (s1_op_q)
            OP_READ:  res_d = s1_a_q;
            OP_WRITE: begin res_d = s1_din_q; wr_en = 1'b1; end
            OP_ADD:   begin arith = 1'b1; wr_en = 1'b1; end
            OP_ADC:   begin arith = 1'b1; wr_en = 1'b1; cin = flags_q[1]; end
            OP_SUB:   begin arith = 1'b1; wr_en = 1'b1; opb = ~s1_b_q; cin = 1'b1; end
            OP_SBC:   begin arith = 1'b1; wr_en = 1'b1; opb = ~s1_b_q; cin = flags_q[1]; end
            OP_CMP:   begin arith = 1'b1; opb = ~s1_b_q; cin = 1'b1; end
            OP_AND:   begin res_d = s1_a_q & s1_b_q; wr_en = 1'b1; flag_upd = 1'b1; end
            OP_OR:    begin res_d = s1_a_q | s1_b_q; wr_en = 1'b1; flag_upd = 1'b1; end
            OP_XOR:   begin res_d = s1_a_q ^ s1_b_q; wr_en = 1'b1; flag_upd = 1'b1; end
            default:  res_d = '0;
        endcase
        sum = {1'b0, s1_a_q} + {1'b0, opb} + {{DATA_BITS{1'b0}}, cin};
        flags_d = flags_q;
        if (arith) begin
            res_d   = sum[MSB:0];
            flags_d = {res_d[MSB], res_d == '0, sum[DATA_BITS],
                       (s1_a_q[MSB] == opb[MSB]) && (res_d[MSB] != s1_a_q[MSB])};
        end else if (flag_upd) begin
            flags_d = {res_d[MSB], res_d == '0, 2'b00};
        end
        wr_en = wr_en && s1_valid_q;
        if (!s1_valid_q) flags_d = flags_q;
    end

    always_comb begin
        opa_byp = rf_q[addr_a];
        opb_byp = rf_q[addr_b];
        if (wr_en && s1_dest_q == addr_a) opa_byp = res_d;
        if (wr_en && s1_dest_q == addr_b) opb_byp = res_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            flags_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_din_q    <= '0;
            s1_dest_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else if (adv) begin
            if (wr_en) rf_q[s1_dest_q] <= res_d;
            flags_q     <= flags_d;
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q  <= res_d;
                out_flags_q <= flags_d;
            end
            s1_valid_q <= accept;
            if (accept) begin
                s1_op_q   <= op;
                s1_a_q    <= opa_byp;
                s1_b_q    <= opb_byp;
                s1_din_q  <= data_in;
                s1_dest_q <= (op == OP_WRITE) ? addr_a : addr_r;
            end
        end
    end
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed bench for alu_regfile_pipe: streamed vector table plus backpressure and mid-flight reset sequences.
module tb_alu_regfile_pipe;
    typedef struct {
        logic [3:0] op;
        logic [2:0] a, b, r;
        logic [7:0] din;
        logic [7:0] ed;
        logic [3:0] ef;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = '0;
    logic [2:0] addr_a = '0, addr_b = '0, addr_r = '0;
    logic [7:0] data_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [3:0] out_flags;

    int total = 0;
    int bad = 0;
    vec_t vecs[$];
    logic [11:0] expq[$];

    alu_regfile_pipe #(.ADDR_BITS(3), .DATA_BITS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .addr_a(addr_a), .addr_b(addr_b), .addr_r(addr_r), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b,
                                input logic [2:0] r, input logic [7:0] d,
                                input logic [7:0] ed, input logic [3:0] ef);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.r = r; v.din = d; v.ed = ed; v.ef = ef;
        return v;
    endfunction

    // Beats are observed at the falling edge, before the rising edge that consumes them.
    task automatic tick();
        logic [11:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                e = expq.pop_front();
                check("out_data", 32'(out_data), 32'(e[11:4]));
                check("out_flags", 32'(out_flags), 32'(e[3:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        op = v.op; addr_a = v.a; addr_b = v.b; addr_r = v.r; data_in = v.din;
        in_valid = 1'b1;
        check("in_ready_stream", 32'(in_ready), 32'd1);
        expq.push_back({v.ed, v.ef});
        tick();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && expq.size() != 0; i++) tick();
        check("drain_left", 32'(expq.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        // {N,Z,C,V}
        for (int i = 0; i < 8; i++) vecs.push_back(mk(4'd1, 3'(i), 3'd0, 3'd0, 8'h00, 8'h00, 4'b0000));
        vecs.push_back(mk(4'd2, 3'd1, 3'd0, 3'd0, 8'h7F, 8'h7F, 4'b0000));
        vecs.push_back(mk(4'd2, 3'd2, 3'd0, 3'd0, 8'h01, 8'h01, 4'b0000));
        vecs.push_back(mk(4'd3, 3'd1, 3'd2, 3'd3, 8'h00, 8'h80, 4'b1001));
        vecs.push_back(mk(4'd3, 3'd1, 3'd2, 3'd3, 8'h00, 8'h80, 4'b1001));
        vecs.push_back(mk(4'd4, 3'd3, 3'd3, 3'd4, 8'h00, 8'h00, 4'b0110));
        vecs.push_back(mk(4'd1, 3'd4, 3'd0, 3'd0, 8'h00, 8'h00, 4'b0110));
        vecs.push_back(mk(4'd2, 3'd1, 3'd0, 3'd0, 8'hFF, 8'hFF, 4'b0110));
        vecs.push_back(mk(4'd7, 3'd1, 3'd2, 3'd7, 8'h00, 8'h01, 4'b0000));
        vecs.push_back(mk(4'd3, 3'd1, 3'd2, 3'd5, 8'h00, 8'h00, 4'b0110));
        vecs.push_back(mk(4'd5, 3'd0, 3'd0, 3'd6, 8'h00, 8'h01, 4'b0000));
        vecs.push_back(mk(4'd10, 3'd1, 3'd2, 3'd6, 8'h00, 8'hFE, 4'b1010));
        vecs.push_back(mk(4'd1, 3'd6, 3'd0, 3'd0, 8'h00, 8'h01, 4'b1010));
        vecs.push_back(mk(4'd6, 3'd2, 3'd1, 3'd7, 8'h00, 8'h02, 4'b0000));
        vecs.push_back(mk(4'd8, 3'd1, 3'd2, 3'd0, 8'h00, 8'hFF, 4'b1000));
        vecs.push_back(mk(4'd9, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 4'b0100));
        vecs.push_back(mk(4'd0, 3'd1, 3'd2, 3'd3, 8'hAA, 8'h00, 4'b0100));
        vecs.push_back(mk(4'd13, 3'd1, 3'd2, 3'd3, 8'hAA, 8'h00, 4'b0100));
        vecs.push_back(mk(4'd1, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 4'b0100));
        vecs.push_back(mk(4'd2, 3'd3, 3'd0, 3'd0, 8'h80, 8'h80, 4'b0100));
        vecs.push_back(mk(4'd4, 3'd3, 3'd2, 3'd4, 8'h00, 8'h7F, 4'b0011));
        vecs.push_back(mk(4'd3, 3'd2, 3'd2, 3'd2, 8'h00, 8'h02, 4'b0000));
        vecs.push_back(mk(4'd1, 3'd2, 3'd0, 3'd0, 8'h00, 8'h02, 4'b0000));
        vecs.push_back(mk(4'd2, 3'd5, 3'd0, 3'd0, 8'h11, 8'h11, 4'b0000));
        vecs.push_back(mk(4'd2, 3'd5, 3'd0, 3'd0, 8'h22, 8'h22, 4'b0000));
        vecs.push_back(mk(4'd1, 3'd5, 3'd0, 3'd0, 8'h00, 8'h22, 4'b0000));

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);
        drain();

        // Backpressure: two commands pending while the output is stalled.
        out_ready = 1'b0;
        op = 4'd2; addr_a = 3'd1; data_in = 8'h33; in_valid = 1'b1;
        tick();
        op = 4'd3; addr_a = 3'd1; addr_b = 3'd1; addr_r = 3'd2;
        tick();
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        op = 4'd1; addr_a = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_data", 32'(out_data), 32'h33);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        expq.push_back({8'h33, vecs[vecs.size()-1].ef});
        expq.push_back({8'h66, 4'b0000});
        expq.push_back({8'h66, 4'b0000});
        out_ready = 1'b1;
        tick();
        drain();

        // Reset while both stages are occupied.
        op = 4'd2; addr_a = 3'd3; data_in = 8'h55; in_valid = 1'b1;
        tick();
        addr_a = 3'd4; data_in = 8'h66;
        tick();
        check("mid_out_valid_pre", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out_data", 32'(out_data), 32'd0);
        check("mid_out_flags", 32'(out_flags), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        expq.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) run_vec(mk(4'd1, 3'(i), 3'd0, 3'd0, 8'h00, 8'h00, 4'b0000));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
